// File: rtl/subtractor_nibble_serial_if.sv
// ---------------------------------------------------------------------------
// subtractor_nibble_serial_if
// Handshake and operand/result bundle for the slice-serial subtractor.
//   start     request (master -> slave)
//   a, b      minuend / subtrahend (master -> slave)
//   bin       borrow-in, only when SUB_BORROW_IN_EN is defined (master -> slave)
//   busy      high while the subtraction is running (slave -> master)
//   done      one-cycle pulse when diff/flags were just committed
//   diff      a - b (mod 2^WIDTH), held until the next completion
//   sign, zero, borrow, parity, overflow   result flags
// Optional feature macro: SUB_BORROW_IN_EN (adds bin).
// ---------------------------------------------------------------------------
interface subtractor_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_BORROW_IN_EN
    logic             bin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             sign;
    logic             zero;
    logic             borrow;
    logic             parity;
    logic             overflow;

`ifdef SUB_BORROW_IN_EN
    modport master (output start, a, b, bin,
                    input  busy, done, diff, sign, zero, borrow, parity, overflow);
    modport slave  (input  start, a, b, bin,
                    output busy, done, diff, sign, zero, borrow, parity, overflow);
`else
    modport master (output start, a, b,
                    input  busy, done, diff, sign, zero, borrow, parity, overflow);
    modport slave  (input  start, a, b,
                    output busy, done, diff, sign, zero, borrow, parity, overflow);
`endif
endinterface

// File: rtl/subtractor_nibble_serial.sv
// ---------------------------------------------------------------------------
// subtractor_nibble_serial
// Multi-cycle subtractor: diff = a + ~b + 1, computed SLICE bits per clock
// with a registered carry between slices. Latency WIDTH/SLICE cycles after
// start is accepted; results and flags are committed together.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   subtractor_nibble_serial_if.slave (start/a/b[/bin] in,
//         busy/done/diff/sign/zero/borrow/parity/overflow out)
// Optional feature macro: SUB_BORROW_IN_EN -- adds borrow-in bin,
//   initial carry becomes ~bin, diff = a - b - bin.
// ---------------------------------------------------------------------------
module subtractor_nibble_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    subtractor_nibble_serial_if.slave  bus
);
    localparam int NSL   = WIDTH / SLICE;
    localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             cin0;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] shadow_p1;
    logic             carry_p1;

    logic [SLICE:0]   res;
    logic [WIDTH-1:0] full;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             sign_q;
    logic             zero_q;
    logic             borrow_q;
    logic             parity_q;
    logic             overflow_q;

    // One slice of a + ~b + cin; bit SLICE is the carry-out.
    function automatic logic [SLICE:0] slice_sub(input logic [SLICE-1:0] as,
                                                 input logic [SLICE-1:0] bs,
                                                 input logic             cin);
        return {1'b0, as} + {1'b0, ~bs} + {{SLICE{1'b0}}, cin};
    endfunction

`ifdef SUB_BORROW_IN_EN
    assign cin0 = ~bus.bin;
`else
    assign cin0 = 1'b1;
`endif

    // Operands may only be replaced when no subtraction is in flight.
    assign accept = bus.start && (state != RUN);
    assign last   = (cnt == CNT_W'(NSL - 1));

    always_comb begin
        res  = slice_sub(a_p0[int'(cnt)*SLICE +: SLICE],
                         b_p0[int'(cnt)*SLICE +: SLICE], carry_p1);
        full = shadow_p1;
        full[int'(cnt)*SLICE +: SLICE] = res[SLICE-1:0];
    end

    // ---- stage p0/p1: operand latch and serial slice datapath ----
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0     <= bus.a;
            b_p0     <= bus.b;
            carry_p1 <= cin0;
        end else if (state == RUN) begin
            shadow_p1 <= full;
            carry_p1  <= res[SLICE];
        end
    end

    // ---- control FSM and committed outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            borrow_q   <= 1'b0;
            parity_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // Result and every flag land on the same edge, so diff
                        // never shows a partially assembled value.
                        state      <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        diff_q     <= full;
                        sign_q     <= full[WIDTH-1];
                        zero_q     <= (full == '0);
                        borrow_q   <= ~res[SLICE];
                        parity_q   <= ~^full;
                        overflow_q <= (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]) &
                                      (full[WIDTH-1] ^ a_p0[WIDTH-1]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.sign     = sign_q;
    assign bus.zero     = zero_q;
    assign bus.borrow   = borrow_q;
    assign bus.parity   = parity_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_subtractor_nibble_serial.sv
// ---------------------------------------------------------------------------
// tb_subtractor_nibble_serial
// Self-checking bench for subtractor_nibble_serial: directed cases followed by
// random operands, compared against an integer-arithmetic reference model.
// Builds with or without SUB_BORROW_IN_EN.
// ---------------------------------------------------------------------------
module tb_subtractor_nibble_serial;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [W-1:0] held_diff = '0;
    logic held_s = 1'b0, held_z = 1'b0, held_b = 1'b0, held_p = 1'b0, held_v = 1'b0;

    always #5 clk = ~clk;

    subtractor_nibble_serial_if #(.WIDTH(W)) sbif ();

    subtractor_nibble_serial #(.WIDTH(W), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sbif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic s, output logic z,
                         output logic bo, output logic p, output logic v);
        int u;
        int sr;
        u  = int'(a) - int'(b) - int'(bin);
        d  = W'(u);
        bo = (u < 0);
        s  = d[W-1];
        z  = (d == 0);
        p  = ($countones(d) % 2) == 0;
        sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
        v  = (sr > 32767) || (sr < -32768);
    endtask

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin);
        sbif.start = st;
        sbif.a     = a;
        sbif.b     = b;
`ifdef SUB_BORROW_IN_EN
        sbif.bin   = bin;
`endif
    endtask

    task automatic check_held(input string tag);
        chk({tag, ".diff_held"}, 32'(sbif.diff), 32'(held_diff));
        chk({tag, ".flags_held"},
            {27'd0, sbif.sign, sbif.zero, sbif.borrow, sbif.parity, sbif.overflow},
            {27'd0, held_s, held_z, held_b, held_p, held_v});
    endtask

    // Caller is at a negedge having just driven start=1 with the operands.
    // Returns at the negedge of the done cycle. Optionally pokes a start
    // with other operands during RUN, which must be ignored.
    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bin, input bit poke);
        logic [W-1:0] ed;
        logic es, ez, eb, ep, ev;
        model(a, b, bin, ed, es, ez, eb, ep, ev);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b0, a, b, bin);
            if (poke && i == 2) drive(1'b1, 16'h0009, 16'h0002, 1'b0);
            if (poke && i == 3) drive(1'b0, 16'h0009, 16'h0002, 1'b0);
            chk({tag, ".busy"}, 32'(sbif.busy), 32'd1);
            chk({tag, ".done_early"}, 32'(sbif.done), 32'd0);
            check_held(tag);
        end
        @(negedge clk);
        chk({tag, ".done"}, 32'(sbif.done), 32'd1);
        chk({tag, ".busy_end"}, 32'(sbif.busy), 32'd0);
        chk({tag, ".diff"}, 32'(sbif.diff), 32'(ed));
        chk({tag, ".sign"}, 32'(sbif.sign), 32'(es));
        chk({tag, ".zero"}, 32'(sbif.zero), 32'(ez));
        chk({tag, ".borrow"}, 32'(sbif.borrow), 32'(eb));
        chk({tag, ".parity"}, 32'(sbif.parity), 32'(ep));
        chk({tag, ".overflow"}, 32'(sbif.overflow), 32'(ev));
        held_diff = ed; held_s = es; held_z = ez; held_b = eb; held_p = ep; held_v = ev;
    endtask

    // Single operation starting from IDLE; checks the done pulse is one cycle.
    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bin);
        drive(1'b1, a, b, bin);
        finish_op(tag, a, b, bin, 1'b0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(sbif.done), 32'd0);
        check_held(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(sbif.busy), 32'd0);
        chk("rst.done", 32'(sbif.done), 32'd0);
        chk("rst.zero", 32'(sbif.zero), 32'd0);
        check_held("rst");
        rst = 1'b0;
        @(negedge clk);

        op("t1", 16'h0005, 16'h0003, 1'b0);
        chk("t1.diff_lit", 32'(sbif.diff), 32'h0002);
        op("t2", 16'h1234, 16'h1234, 1'b0);
        chk("t2.zero_lit", 32'(sbif.zero), 32'd1);
        op("t3", 16'h0000, 16'h0001, 1'b0);
        chk("t3.diff_lit", 32'(sbif.diff), 32'hFFFF);
        chk("t3.borrow_lit", 32'(sbif.borrow), 32'd1);
        op("t4", 16'h8000, 16'h0001, 1'b0);
        chk("t4.ovf_lit", 32'(sbif.overflow), 32'd1);

        // Start ignored while busy.
        drive(1'b1, 16'h0001, 16'h0001, 1'b0);
        finish_op("t5", 16'h0001, 16'h0001, 1'b0, 1'b1);
        chk("t5.diff_lit", 32'(sbif.diff), 32'h0000);
        @(negedge clk);

        // Reset in the middle of RUN: everything clears, no done follows.
        drive(1'b1, 16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held_diff = '0; held_s = 0; held_z = 0; held_b = 0; held_p = 0; held_v = 0;
        chk("t5r.busy", 32'(sbif.busy), 32'd0);
        check_held("t5r");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5r.no_done", 32'(sbif.done), 32'd0);
            chk("t5r.no_busy", 32'(sbif.busy), 32'd0);
        end
        check_held("t5r.after");
        op("t5n", 16'h00F0, 16'h000F, 1'b0);

`ifdef SUB_BORROW_IN_EN
        drive(1'b1, 16'h0005, 16'h0005, 1'b1);
        finish_op("t6a", 16'h0005, 16'h0005, 1'b1, 1'b0);
        chk("t6a.diff_lit", 32'(sbif.diff), 32'hFFFF);
        chk("t6a.borrow_lit", 32'(sbif.borrow), 32'd1);
        drive(1'b1, 16'h0007, 16'h0002, 1'b0);
        finish_op("t6b", 16'h0007, 16'h0002, 1'b0, 1'b0);
        chk("t6b.diff_lit", 32'(sbif.diff), 32'h0005);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
`endif

        // Random operands, randomly back-to-back or through IDLE.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = 16'h0000;
                default: ;
            endcase
`ifdef SUB_BORROW_IN_EN
            rbin = 1'($urandom);
`else
            rbin = 1'b0;
`endif
            drive(1'b1, ra, rb, rbin);
            finish_op("rnd", ra, rb, rbin, 1'b0);
            if ($urandom_range(0, 1) == 0) begin
                drive(1'b0, ra, rb, rbin);
                @(negedge clk);
                chk("rnd.idle_done", 32'(sbif.done), 32'd0);
                chk("rnd.idle_busy", 32'(sbif.busy), 32'd0);
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
